// File: rtl/lc_pkg.sv
// lc_pkg: shared types and defaults for the DRAM-to-UART dump block.
// Optional feature macro: DUMP_CHECKSUM_EN (adds the ST_CHK state).
package lc_pkg;

    localparam int LC_ADDR_WIDTH  = 25;
    localparam int LC_COUNT_WIDTH = 16;
    localparam int LC_SUM_WIDTH   = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_SEND_HI   = 3'd3,
        ST_WAIT_HI   = 3'd4,
        ST_SEND_LO   = 3'd5,
        ST_WAIT_LO   = 3'd6
`ifdef DUMP_CHECKSUM_EN
        , ST_CHK     = 3'd7
`endif
    } dump_state_t;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_FALL = 2'd1,
        HS_RISE = 2'd2
    } hs_state_t;

    typedef struct packed {
        dump_state_t dump;
        hs_state_t   hs;
    } dbg_t;

endpackage

// File: rtl/defs.vh
// defs.vh: project-wide build constants shared by the RTL.
`ifndef DEFS_VH
`define DEFS_VH

// SDRAM data word width (must be even; the top splits it into high/low bytes).
`define DEFS_WORD_WIDTH 16

`endif

// File: rtl/uart_byte_handshake.sv
// uart_byte_handshake: sends one byte over the tx_start_n/tx_ready pair.
// launch pulses when the byte is accepted; complete pulses when tx_ready
// has gone low and come back high, i.e. the transmitter finished the byte.
module uart_byte_handshake
    import lc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] byte_in,
    input  logic       tx_ready,
    output logic       tx_start_n,
    output logic [7:0] tx_byte,
    output logic       launch,
    output logic       complete,
    output hs_state_t  hs_state
);

    hs_state_t state, next_state;

    assign hs_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HS_IDLE;
        else      state <= next_state;
    end

    // Next state: start when idle and ready, then see ready fall and rise.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        complete   = 1'b0;
        case (state)
            HS_IDLE: if (go && tx_ready) begin
                launch     = 1'b1;
                next_state = HS_FALL;
            end
            HS_FALL: if (!tx_ready) next_state = HS_RISE;
            HS_RISE: if (tx_ready) begin
                complete   = 1'b1;
                next_state = HS_IDLE;
            end
            default: next_state = HS_IDLE;
        endcase
    end

    // Registered strobe and byte; the byte holds until the next launch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_start_n <= 1'b1;
            tx_byte    <= 8'h00;
        end else begin
            tx_start_n <= ~launch;
            if (launch) tx_byte <= byte_in;
        end
    end

endmodule

// File: rtl/dram_uart_dump.sv
// dram_uart_dump: reads word_count words from SDRAM starting at base_addr and
// sends each one to the UART, high byte first. One read is outstanding at a
// time; the next read waits until the low byte has gone out.
// Optional feature macro: DUMP_CHECKSUM_EN appends a 16-bit sum of all words
// (high byte, then low byte) before done.
//
// Handshakes: a read is one mem_refresh strobe with mem_addr held until the
// first cycle of mem_data_ready, when mem_data is taken. A byte is offered
// only while tx_ready=1 with a one-cycle tx_start_n=0, and is finished once
// tx_ready has dropped and risen again.
`include "defs.vh"

module dram_uart_dump
    import lc_pkg::*;
#(
    parameter int WORD_WIDTH = `DEFS_WORD_WIDTH,
    parameter int ADDR_WIDTH = LC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           word_count,
    input  logic                  mem_ready,
    output logic                  mem_refresh,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_en,
    input  logic [WORD_WIDTH-1:0] mem_data,
    input  logic                  mem_data_ready,
    output logic [7:0]            tx_byte,
    output logic                  tx_start_n,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done,
    output dbg_t                  dbg_state
);

    dump_state_t state, next_state;

    logic [LC_COUNT_WIDTH-1:0] count_q, index_q, index_inc;
    logic [WORD_WIDTH-1:0]     word_q;
    logic                      accept, capture, word_done, finish;
    logic                      hs_go, hs_launch, hs_complete;
    logic [7:0]                hs_byte;
    hs_state_t                 hs_state;

`ifdef DUMP_CHECKSUM_EN
    logic [LC_SUM_WIDTH-1:0] sum_q, word16;
    logic [1:0]              chk_step;
    logic                    chk_adv;
    assign word16 = LC_SUM_WIDTH'(mem_data);
`endif

    assign index_inc    = index_q + LC_COUNT_WIDTH'(1);
    assign mem_refresh  = (state == ST_REQ);
    assign mem_write_en = 1'b0;
    assign busy         = (state != ST_IDLE);
    assign dbg_state    = '{dump: state, hs: hs_state};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        word_done  = 1'b0;
        finish     = 1'b0;
        hs_go      = 1'b0;
        hs_byte    = word_q[WORD_WIDTH-1 -: 8];
`ifdef DUMP_CHECKSUM_EN
        chk_adv    = 1'b0;
`endif
        case (state)
            ST_IDLE: if (start && mem_ready) begin
                accept = 1'b1;
                if (word_count == '0) begin
`ifdef DUMP_CHECKSUM_EN
                    next_state = ST_CHK;
`else
                    finish = 1'b1;
`endif
                end else begin
                    next_state = ST_REQ;
                end
            end
            ST_REQ: next_state = ST_WAIT_DATA;
            ST_WAIT_DATA: if (mem_data_ready) begin
                capture    = 1'b1;
                next_state = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                hs_go = 1'b1;
                if (hs_launch) next_state = ST_WAIT_HI;
            end
            ST_WAIT_HI: if (hs_complete) next_state = ST_SEND_LO;
            ST_SEND_LO: begin
                hs_go   = 1'b1;
                hs_byte = word_q[7:0];
                if (hs_launch) next_state = ST_WAIT_LO;
            end
            ST_WAIT_LO: if (hs_complete) begin
                word_done = 1'b1;
                if (index_inc == count_q) begin
`ifdef DUMP_CHECKSUM_EN
                    next_state = ST_CHK;
`else
                    next_state = ST_IDLE;
                    finish     = 1'b1;
`endif
                end else begin
                    next_state = ST_REQ;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            // Steps: 0 send high, 1 wait high, 2 send low, 3 wait low.
            ST_CHK: begin
                hs_byte = chk_step[1] ? sum_q[7:0] : sum_q[15:8];
                if (!chk_step[0]) begin
                    hs_go = 1'b1;
                    if (hs_launch) chk_adv = 1'b1;
                end else if (hs_complete) begin
                    if (chk_step[1]) begin
                        next_state = ST_IDLE;
                        finish     = 1'b1;
                    end else begin
                        chk_adv = 1'b1;
                    end
                end
            end
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath: latch the job, track index/address, capture words, pulse done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr <= '0;
            count_q  <= '0;
            index_q  <= '0;
            word_q   <= '0;
            done     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_q    <= '0;
            chk_step <= '0;
`endif
        end else begin
            done <= finish;
            if (accept) begin
                mem_addr <= base_addr;
                count_q  <= word_count;
                index_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
                sum_q    <= '0;
                chk_step <= '0;
`endif
            end
            if (capture) begin
                word_q <= mem_data;
`ifdef DUMP_CHECKSUM_EN
                sum_q  <= sum_q + word16;
`endif
            end
            if (word_done) begin
                index_q  <= index_inc;
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
            end
`ifdef DUMP_CHECKSUM_EN
            if (chk_adv) chk_step <= chk_step + 2'd1;
`endif
        end
    end

    uart_byte_handshake u_hs (
        .clk        (clk),
        .rst        (rst),
        .go         (hs_go),
        .byte_in    (hs_byte),
        .tx_ready   (tx_ready),
        .tx_start_n (tx_start_n),
        .tx_byte    (tx_byte),
        .launch     (hs_launch),
        .complete   (hs_complete),
        .hs_state   (hs_state)
    );

endmodule

// File: tb/tb_dram_uart_dump.sv
// tb_dram_uart_dump: directed table plus randomized dumps against a
// queue-based model of the expected read addresses and UART byte stream.
module tb_dram_uart_dump;
  import lc_pkg::*;

  localparam int AW = 25;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [15:0]   word_count;
  logic          mem_ready;
  logic          mem_refresh;
  logic [AW-1:0] mem_addr;
  logic          mem_write_en;
  logic [WW-1:0] mem_data;
  logic          mem_data_ready;
  logic [7:0]    tx_byte;
  logic          tx_start_n;
  logic          tx_ready;
  logic          busy;
  logic          done;
  dbg_t          dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int          proto_err = 0;
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  bit          busy_seen = 0;
  bit          hold_mode = 0;
  bit          hold_pending = 0;
  bit          no_stab_chk = 0;
  int          mem_lat_force = 0;

  logic [15:0]   mem_img [bit [AW-1:0]];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] exp_rd[$];
  logic [7:0]    tx_log[$];
  logic [7:0]    exp_q[$];

  typedef struct {
    logic [AW-1:0] base;
    logic [15:0]   cnt;
    bit            hold;
    logic [15:0]   w0;
    logic [15:0]   w1;
    int            exp_reads;
    logic [AW-1:0] exp_last;
  } vec_t;

  dram_uart_dump #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .mem_ready      (mem_ready),
    .mem_refresh    (mem_refresh),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_data       (mem_data),
    .mem_data_ready (mem_data_ready),
    .tx_byte        (tx_byte),
    .tx_start_n     (tx_start_n),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Done/busy monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy !== 1'b0) proto_err++;
      end
    end
  end

  // SDRAM responder: random latency, data held 1-3 cycles, address stability checked.
  initial begin
    logic [AW-1:0] ra;
    int lat;
    mem_data_ready = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (mem_refresh === 1'b1) begin
        ra = mem_addr;
        rd_log.push_back(ra);
        lat = (mem_lat_force != 0) ? mem_lat_force : int'($urandom_range(1, 4));
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          mem_data = 16'($urandom);
          if (!no_stab_chk && (mem_refresh !== 1'b0 || mem_addr !== ra)) proto_err++;
        end
        mem_data = mem_img.exists(ra) ? mem_img[ra] : 16'hDEAD;
        mem_data_ready = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        mem_data_ready = 1'b0;
        mem_data = 16'($urandom);
      end
    end
  end

  // UART responder: logs bytes, checks no start while not ready and byte stability.
  initial begin
    logic [7:0] b;
    int n;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (hold_pending) begin
        tx_ready = 1'b0;
        repeat (100) begin
          @(negedge clk);
          if (tx_start_n === 1'b0) proto_err++;
        end
        tx_ready = 1'b1;
        hold_pending = 0;
      end else if (tx_start_n === 1'b0) begin
        if (tx_ready !== 1'b1) proto_err++;
        b = tx_byte;
        tx_log.push_back(b);
        tx_ready = 1'b0;
        n = $urandom_range(2, 6);
        for (int k = 0; k < n; k++) begin
          @(negedge clk);
          if (tx_start_n === 1'b0 || tx_byte !== b) proto_err++;
        end
        tx_ready = 1'b1;
        if (hold_mode) hold_pending = 1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_refresh"}, 32'(mem_refresh), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_write_en"}, 32'(mem_write_en), 32'd0);
    check({tag, "_tx_start_n"}, 32'(tx_start_n), 32'd1);
    check({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // One dump: build expectations from the memory image, run, compare.
  task automatic run_dump(input logic [AW-1:0] base, input logic [15:0] cnt,
                          input bit hold, input bit extra);
    logic [AW-1:0] a;
    logic [15:0] w;
    int unsigned sum;
    int unsigned t0;
    sum = 0;
    exp_rd.delete();
    exp_q.delete();
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + AW'(i);
      if (!mem_img.exists(a)) mem_img[a] = 16'($urandom);
      w = mem_img[a];
      exp_rd.push_back(a);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      sum = (sum + int'(w)) % 65536;
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(8'(sum / 256));
    exp_q.push_back(8'(sum % 256));
`endif
    rd_log.delete();
    tx_log.delete();
    done_cnt = 0;
    proto_err = 0;
    hold_mode = hold;
    hold_pending = hold;
    @(negedge clk);
    base_addr = base;
    word_count = cnt;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    base_addr = AW'($urandom);
    word_count = 16'($urandom);
    for (int k = 0; k < 5000 && done_cnt == 0; k++) begin
      start = (extra && k == 4);
      @(negedge clk);
    end
    start = 1'b0;
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    repeat (6) @(negedge clk);
    hold_mode = 0;
    check("done_pulses", 32'(done_cnt), 32'd1);
`ifndef DUMP_CHECKSUM_EN
    if (cnt == 0) check("done_latency", 32'(done_cyc - t0), 32'd1);
`endif
    check("read_count", 32'(rd_log.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check($sformatf("rd_addr[%0d]", i), 32'(rd_log[i]), 32'(exp_rd[i]));
    check("byte_count", 32'(tx_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check($sformatf("tx_byte[%0d]", i), 32'(tx_log[i]), 32'(exp_q[i]));
    check("protocol", 32'(proto_err), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic reset_mid_read();
    mem_lat_force = 20;
    no_stab_chk = 1;
    rd_log.delete();
    @(negedge clk);
    base_addr = 25'h300;
    word_count = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && rd_log.size() == 0; k++) @(negedge clk);
    check("rst_read_issued", 32'(rd_log.size()), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #2 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    rd_log.delete();
    tx_log.delete();
    busy_seen = 0;
    done_cnt = 0;
    repeat (40) @(negedge clk);
    check("rst_late_busy", 32'(busy_seen), 32'd0);
    check("rst_late_reads", 32'(rd_log.size()), 32'd0);
    check("rst_late_bytes", 32'(tx_log.size()), 32'd0);
    check("rst_late_done", 32'(done_cnt), 32'd0);
    mem_lat_force = 0;
    no_stab_chk = 0;
  endtask

  // Main sequence.
  initial begin
    vec_t vecs[5];
    logic [AW-1:0] rb;
    logic [15:0] rc;
    rst = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    vecs[0] = '{base: 25'h10,      cnt: 16'd2, hold: 0, w0: 16'hABCD, w1: 16'h1234, exp_reads: 2, exp_last: 25'h11};
    vecs[1] = '{base: 25'h100,     cnt: 16'd0, hold: 0, w0: 16'h0,    w1: 16'h0,    exp_reads: 0, exp_last: 25'h0};
    vecs[2] = '{base: 25'h1FFFFFF, cnt: 16'd2, hold: 0, w0: 16'h5A5A, w1: 16'hC3C3, exp_reads: 2, exp_last: 25'h0};
    vecs[3] = '{base: 25'h20,      cnt: 16'd3, hold: 1, w0: 16'h0102, w1: 16'h8081, exp_reads: 3, exp_last: 25'h22};
    vecs[4] = '{base: 25'h40,      cnt: 16'd2, hold: 0, w0: 16'hFFFF, w1: 16'h0002, exp_reads: 2, exp_last: 25'h41};

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].cnt >= 1) mem_img[vecs[v].base] = vecs[v].w0;
      if (vecs[v].cnt >= 2) mem_img[vecs[v].base + AW'(1)] = vecs[v].w1;
      run_dump(vecs[v].base, vecs[v].cnt, vecs[v].hold, 1'b0);
      check($sformatf("vec%0d_reads", v), 32'(rd_log.size()), 32'(vecs[v].exp_reads));
      if (vecs[v].exp_reads > 0 && rd_log.size() > 0)
        check($sformatf("vec%0d_last_addr", v), 32'(rd_log[rd_log.size()-1]), 32'(vecs[v].exp_last));
    end

    // start with mem_ready low is ignored
    mem_ready = 1'b0;
    busy_seen = 0;
    done_cnt = 0;
    rd_log.delete();
    @(negedge clk);
    base_addr = 25'h50;
    word_count = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("nrdy_busy", 32'(busy_seen), 32'd0);
    check("nrdy_reads", 32'(rd_log.size()), 32'd0);
    check("nrdy_done", 32'(done_cnt), 32'd0);
    mem_ready = 1'b1;

    reset_mid_read();
    run_dump(25'h300, 16'd2, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      rb = ($urandom_range(0, 1) == 1) ? AW'($urandom) : (25'h1FFFFFF - AW'($urandom_range(0, 3)));
      rc = 16'($urandom_range(0, 5));
      run_dump(rb, rc, 1'b0, (rc != 0) && ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_uart_dump.md
DRAM_UART_DUMP -- requirements
Module: dram_uart_dump

Interface
REQ-001 Parameter WORD_WIDTH, default 16, data word width; SHALL be an even number.
REQ-002 Parameter ADDR_WIDTH, default 25, SDRAM word-address width.
REQ-003 The clock and reset SHALL be one clock and an asynchronous, active-low reset: clk in and rst in.
REQ-004 clk  in  1  system clock (50 MHz).
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a dump.
REQ-007 base_addr  in  ADDR_WIDTH  first word address, sampled on start.
REQ-008 word_count  in  16  number of words to dump, sampled on start.
REQ-009 mem_ready  in  1  SDRAM controller initialised.
REQ-010 mem_refresh  out  1  one-cycle read request strobe to the SDRAM controller.
REQ-011 mem_addr  out  ADDR_WIDTH  read address, held stable from strobe until data_ready.
REQ-012 mem_write_en  out  1  tied 0.
REQ-013 mem_data  in  WORD_WIDTH  read data, valid when mem_data_ready=1.
REQ-014 mem_data_ready  in  1  read data valid, one or more cycles.
REQ-015 tx_byte  out  8  byte to the UART transmitter, held stable from start until tx_ready rises again.
REQ-016 tx_start_n  out  1  active-low one-cycle transmit start.
REQ-017 tx_ready  in  1  transmitter idle.
REQ-018 busy  out  1  dump in progress.
REQ-019 done  out  1  one-cycle pulse after the last byte completes.

Function
REQ-020 FSM states SHALL be: IDLE, REQ, WAIT_DATA, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, and CHK (CHK exists only with the macro).
REQ-021 In IDLE, start=1 with mem_ready=1 SHALL latch base_addr and word_count, zero the index, and enter REQ.
- start with mem_ready=0 is ignored.
- start while busy is ignored.
REQ-022 With word_count=0, the block SHALL go straight to completion: no reads, and done asserts 1 cycle after start.
REQ-023 REQ SHALL drive mem_refresh=1 for exactly one cycle with mem_addr = (base_addr + index) mod 2^ADDR_WIDTH, then enter WAIT_DATA.
REQ-024 On the first cycle WAIT_DATA sees mem_data_ready=1, the block SHALL capture mem_data into a word register and enter SEND_HI.
REQ-025 SEND_HI SHALL wait for tx_ready=1, then drive tx_start_n=0 for one cycle with tx_byte = word[WORD_WIDTH-1:WORD_WIDTH-8], then enter WAIT_HI.
REQ-026 The WAIT_* states SHALL wait for tx_ready to go low and then high again before advancing; high byte is sent first, low byte second.
REQ-027 After WAIT_LO, the block SHALL increment index and then:
- if index = word_count, complete;
- otherwise return to REQ.
REQ-028 Completion SHALL return the FSM to IDLE, pulse done=1 for one cycle, and drop busy in that same cycle.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 The address SHALL wrap modulo 2^ADDR_WIDTH, with no error.
REQ-031 The next read SHALL NOT be requested until the current word's low byte has completed (no prefetch).

Reset
REQ-032 rst=0 SHALL immediately force the following, including mid-dump (an in-flight read result is discarded):
- FSM to IDLE;
- mem_refresh=0, mem_addr=0, tx_start_n=1, tx_byte=0;
- busy=0, done=0;
- index, word register and checksum to 0.

Configuration
REQ-033 Macro DUMP_CHECKSUM_EN controls a trailing checksum.
- When defined: the block SHALL accumulate a 16-bit sum (mod 2^16) of all dumped words. After the last word it SHALL send the sum high byte then low byte via CHK, using the same handshake, before done. With word_count=0 it sends 0x00, 0x00.
- When undefined: there is no CHK state and no accumulator, and done follows the last data byte.

Structure
REQ-034 The state enum and the ADDR_WIDTH default SHALL live in shared package lc_pkg; WORD_WIDTH SHALL come from defs.vh.
REQ-035 The tx_start_n/tx_ready handshake SHALL be a sub-module, uart_byte_handshake, reused by the HI, LO and CHK byte sends.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- base_addr=0x10, word_count=2, memory {0xABCD, 0x1234} -> reads at 0x10 and 0x11; tx bytes AB, CD, 12, 34; done once.
- word_count=0 -> no mem_refresh; done 1 cycle after start (with the macro: bytes 00, 00 first).
- base_addr=0x1FFFFFF, word_count=2 -> reads at 0x1FFFFFF then 0x0000000.
- tx_ready held low for 100 cycles before each byte -> tx_start_n stays 1 until tx_ready=1; byte order is preserved.
- rst pulsed low during WAIT_DATA -> all outputs at reset values; a late mem_data_ready is ignored; the next start dumps correctly.
- With the macro, words {0xFFFF, 0x0002} -> checksum bytes 00, 01 after the data bytes.
